// File: rtl/spram_march_pkg.sv
// spram_march_pkg: shared types for the March C- single-port RAM test fixture.
// State encoding, element indices and per-element op descriptors.
package spram_march_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;

  typedef struct packed {
    logic down;
    logic two_ops;
    logic rd_first;
    logic rd_pol;
    logic wr_pol;
  } elem_desc_t;

  // Single-op elements: M0 is a lone write, M5 a lone read.
  function automatic elem_desc_t elem_desc(input logic [2:0] e);
    elem_desc_t d;
    d = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    case (e)
      M0: d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      M1: d = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      M2: d = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      M3: d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      M4: d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      M5: d = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/spram_march_seq.sv
// spram_march_seq: walks March C- elements, addresses and ops.
// Presents the next op; advances on step, otherwise rewinds to the start.
module spram_march_seq
  import spram_march_pkg::*;
#(
  parameter int ADDR_SZ = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  output logic [2:0]         elem,
  output logic [ADDR_SZ-1:0] addr,
  output logic               rd,
  output logic               pol,
  output logic               last
);

  localparam logic [ADDR_SZ-1:0] AMAX = '1;

  elem_desc_t d;
  logic op;
  logic op_last;
  logic term;

  assign d       = elem_desc(elem);
  assign op_last = (op == d.two_ops);
  assign term    = d.down ? (addr == '0) : (addr == AMAX);
  assign rd      = d.rd_first & ~op;
  assign pol     = rd ? d.rd_pol : d.wr_pol;
  assign last    = (elem == M5) & op_last & term;

  // Terminal-value wrap: the counter never relies on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem <= M0;
      addr <= '0;
      op   <= 1'b0;
    end else if (!step) begin
      elem <= M0;
      addr <= '0;
      op   <= 1'b0;
    end else if (!op_last) begin
      op <= 1'b1;
    end else begin
      op <= 1'b0;
      if (term) begin
        elem <= elem + 3'd1;
        addr <= elem_desc(elem + 3'd1).down ? AMAX : '0;
      end else begin
        addr <= d.down ? addr - 1'b1 : addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spram_march_test.sv
// spram_march_test: March C- self-test fixture for a synchronous SPRAM.
// One op per cycle; reads are checked RD_LAT cycles later.
module spram_march_test
  import spram_march_pkg::*;
#(
  parameter int ADDR_SZ = 14,
  parameter int DATA_SZ = 16,
  parameter logic [DATA_SZ-1:0] BACKGROUND = {DATA_SZ/2{2'b01}},
  parameter int RD_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run,
  output logic               o_running,
  output logic               o_done,
  output logic               o_passed,
  output logic [ADDR_SZ-1:0] o_fail_addr,
  output logic [DATA_SZ-1:0] o_fail_data,
  output logic [2:0]         o_fail_elem,
  output logic [ADDR_SZ-1:0] o_addr,
  output logic               o_wr_en,
  output logic [DATA_SZ-1:0] o_wdata,
  input  logic [DATA_SZ-1:0] i_rdata
);

  state_t state;

  logic [2:0]         s_elem;
  logic [ADDR_SZ-1:0] s_addr;
  logic               s_rd;
  logic               s_pol;
  logic               s_last;
  logic [DATA_SZ-1:0] s_data;

  logic       start;
  logic       step;
  logic       active;
  logic       mis;
  logic       last_q;
  logic [1:0] drain_cnt;

  logic               pv    [RD_LAT+1];
  logic [DATA_SZ-1:0] pexp  [RD_LAT+1];
  logic [ADDR_SZ-1:0] paddr [RD_LAT+1];
  logic [2:0]         pelem [RD_LAT+1];

  assign s_data = s_pol ? ~BACKGROUND : BACKGROUND;
  assign active = (state == S_RUN) || (state == S_DRAIN);
  assign start  = (state == S_IDLE) && i_run;
  assign mis    = active && pv[RD_LAT]
                  && (i_rdata != pexp[RD_LAT]);
  assign step   = start
                  || ((state == S_RUN) && i_run
                      && !last_q && !mis);

  spram_march_seq #(
    .ADDR_SZ(ADDR_SZ)
  ) u_seq (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .step (step),
    .elem (s_elem),
    .addr (s_addr),
    .rd   (s_rd),
    .pol  (s_pol),
    .last (s_last)
  );

  // Stage 0 lines up with the op on the RAM bus; stage RD_LAT with i_rdata.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        pv[i]    <= 1'b0;
        pexp[i]  <= '0;
        paddr[i] <= '0;
        pelem[i] <= '0;
      end
    end else begin
      pv[0]    <= step & s_rd;
      pexp[0]  <= s_data;
      paddr[0] <= s_addr;
      pelem[0] <= s_elem;
      for (int i = 1; i <= RD_LAT; i++) begin
        pv[i]    <= pv[i-1] & active;
        pexp[i]  <= pexp[i-1];
        paddr[i] <= paddr[i-1];
        pelem[i] <= pelem[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      o_running   <= 1'b0;
      o_done      <= 1'b0;
      o_passed    <= 1'b0;
      o_fail_addr <= '0;
      o_fail_data <= '0;
      o_fail_elem <= '0;
      o_addr      <= '0;
      o_wr_en     <= 1'b0;
      o_wdata     <= '0;
      last_q      <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      if (step) begin
        o_addr  <= s_addr;
        o_wr_en <= ~s_rd;
        o_wdata <= s_rd ? '0 : s_data;
        last_q  <= s_last;
      end
      unique case (state)
        S_IDLE: begin
          if (i_run) begin
            state       <= S_RUN;
            o_running   <= 1'b1;
            o_done      <= 1'b0;
            o_passed    <= 1'b0;
            o_fail_addr <= '0;
            o_fail_data <= '0;
            o_fail_elem <= '0;
          end
        end
        S_RUN, S_DRAIN: begin
          if (!i_run) begin
            state     <= S_IDLE;
            o_running <= 1'b0;
            o_wr_en   <= 1'b0;
            o_wdata   <= '0;
          end else if (mis) begin
            state       <= S_DONE;
            o_running   <= 1'b0;
            o_done      <= 1'b1;
            o_passed    <= 1'b0;
            o_fail_addr <= paddr[RD_LAT];
            o_fail_data <= i_rdata;
            o_fail_elem <= pelem[RD_LAT];
            o_wr_en     <= 1'b0;
            o_wdata     <= '0;
          end else if (state == S_RUN) begin
            if (last_q) begin
              state     <= S_DRAIN;
              o_wr_en   <= 1'b0;
              o_wdata   <= '0;
              drain_cnt <= '0;
            end
          end else if (drain_cnt == 2'(RD_LAT - 1)) begin
            state     <= S_DONE;
            o_running <= 1'b0;
            o_done    <= 1'b1;
            o_passed  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        S_DONE: begin
          if (!i_run) begin
            state    <= S_IDLE;
            o_done   <= 1'b0;
            o_passed <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
